// File: rtl/div_pkg.sv
// div_pkg: shared FSM encoding and sizing for the sequential restoring divider
package div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DIV_WIDTH = 4;

    // Counter must be able to hold values up to 2*w (one per quotient bit).
    function automatic int cnt_w(input int w);
        return $clog2(2 * w + 1);
    endfunction

    localparam int CNT_W = cnt_w(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step (shift in a dividend bit, trial-subtract)
// Ports: r (partial remainder, W+1), d (next dividend bit), divisor (W)
//        -> r_next (updated partial remainder, W+1), q (quotient bit)
module div_step
    import div_pkg::*;
#(
    parameter int W = DIV_WIDTH
) (
    input  logic [W:0]   r,
    input  logic         d,
    input  logic [W-1:0] divisor,
    output logic [W:0]   r_next,
    output logic         q
);

    logic [W:0] rs;

    assign rs = {r[W-1:0], d};
    // r[W] is always 0 between steps; folding it in keeps the step correct even if it were not.
    assign q = r[W] | (rs >= {1'b0, divisor});
    assign r_next = q ? rs - {1'b0, divisor} : rs;

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock
// Ports: clk, rst_n (async active-low), start, dividend (2W), divisor (W)
//        -> busy, done (1-cycle pulse), quotient (2W), remainder (W), div_by_zero
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    localparam int N  = 2 * WIDTH;
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state, next_state;
    logic [WIDTH:0]   r, r_nx;
    logic [N-1:0]     dsr, qsr;
    logic [WIDTH-1:0] dreg;
    logic [CW-1:0]    cnt;
    logic             q_bit;

    div_step #(.W(WIDTH)) u_step (
        .r       (r),
        .d       (dsr[N-1]),
        .divisor (dreg),
        .r_next  (r_nx),
        .q       (q_bit)
    );

    assign busy = state != IDLE;
    assign done = state == DONE;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? (divisor == '0 ? DONE : RUN) : IDLE;
            RUN:     next_state = cnt == LAST ? DONE : RUN;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r           <= '0;
            dsr         <= '0;
            qsr         <= '0;
            dreg        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                r    <= '0;
                dsr  <= dividend;
                qsr  <= '0;
                dreg <= divisor;
                cnt  <= '0;
            end else if (state == RUN) begin
                r   <= r_nx;
                dsr <= {dsr[N-2:0], 1'b0};
                qsr <= {qsr[N-2:0], q_bit};
                cnt <= cnt + 1'b1;
            end
            // Results change only on entry to DONE, so they hold between done pulses.
            if (state == RUN && next_state == DONE) begin
                quotient    <= {qsr[N-2:0], q_bit};
                remainder   <= r_nx[WIDTH-1:0];
                div_by_zero <= 1'b0;
            end else if (state == IDLE && next_state == DONE) begin
                quotient    <= '1;
                remainder   <= dividend[WIDTH-1:0];
                div_by_zero <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (vector table, corner sequences, random + exhaustive)
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient;
    logic [3:0] remainder;

    int checks = 0;
    int errors = 0;

    logic [7:0] hq = '0;
    logic [3:0] hr = '0;
    logic       hz = 1'b0;

    typedef struct {
        logic [7:0] dd;
        logic [3:0] dv;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer division; a zero divisor yields all-ones quotient and the low dividend nibble.
    function automatic logic [12:0] model(input logic [7:0] dd, input logic [3:0] dv);
        return dv == 0 ? {8'hFF, dd[3:0], 1'b1} : {8'(dd / dv), 4'(dd % dv), 1'b0};
    endfunction

    task automatic run_op(input logic [7:0] dd, input logic [3:0] dv,
                          output logic [7:0] q, output logic [3:0] r, output logic z, output int lat);
        bit held = 1;
        @(negedge clk);
        start = 1'b1;
        dividend = dd;
        divisor = dv;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        lat = 0;
        while (!done && lat < 40) begin
            if (quotient !== hq || remainder !== hr || div_by_zero !== hz) held = 0;
            @(posedge clk); #1;
            lat++;
        end
        chk("done_seen", done, 1);
        chk("results_held", held, 1);
        q = quotient;
        r = remainder;
        z = div_by_zero;
        hq = q;
        hr = r;
        hz = z;
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("busy_clear", busy, 0);
        chk("hold_after_done", {quotient, remainder, div_by_zero}, {q, r, z});
    endtask

    task automatic run_model(input logic [7:0] dd, input logic [3:0] dv);
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
        logic [12:0] e;
        e = model(dd, dv);
        run_op(dd, dv, q, r, z, lat);
        chk("model_result", {q, r, z}, e);
        chk("model_latency", lat, dv == 0 ? 0 : 8);
    endtask

    initial begin
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
        int         n;
        bit         stay_idle;

        tbl[0] = '{8'h6F, 4'h7, 8'h0F, 4'h6, 1'b0, 8};
        tbl[1] = '{8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0, 8};
        tbl[2] = '{8'h0A, 4'hF, 8'h00, 4'hA, 1'b0, 8};
        tbl[3] = '{8'h35, 4'h0, 8'hFF, 4'h5, 1'b1, 0};
        tbl[4] = '{8'h20, 4'h3, 8'h0A, 4'h2, 1'b0, 8};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, quotient, remainder, div_by_zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_op(tbl[i].dd, tbl[i].dv, q, r, z, lat);
            chk($sformatf("tbl%0d_quotient", i), q, tbl[i].q);
            chk($sformatf("tbl%0d_remainder", i), r, tbl[i].r);
            chk($sformatf("tbl%0d_dbz", i), z, tbl[i].z);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
        end

        // start during RUN and during DONE must be ignored and not queued
        @(negedge clk);
        start = 1'b1;
        dividend = 8'h6F;
        divisor = 4'h7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        dividend = 8'h35;
        divisor = 4'h0;
        @(posedge clk); #1;
        start = 1'b0;
        n = 4;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ign_done_latency", n, 8);
        chk("ign_run_result", {quotient, remainder, div_by_zero}, {8'h0F, 4'h6, 1'b0});
        start = 1'b1;
        dividend = 8'h20;
        divisor = 4'h3;
        @(posedge clk); #1;
        start = 1'b0;
        stay_idle = 1;
        repeat (3) begin
            if (busy !== 1'b0 || done !== 1'b0) stay_idle = 0;
            @(posedge clk); #1;
        end
        chk("ign_not_queued", stay_idle, 1);
        chk("ign_done_result", {quotient, remainder, div_by_zero}, {8'h0F, 4'h6, 1'b0});
        hq = 8'h0F;
        hr = 4'h6;
        hz = 1'b0;

        // asynchronous reset mid-operation clears everything at once
        run_op(8'h35, 4'h0, q, r, z, lat);
        @(negedge clk);
        start = 1'b1;
        dividend = 8'h6F;
        divisor = 4'h7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {busy, done, quotient, remainder, div_by_zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hq = '0;
        hr = '0;
        hz = 1'b0;
        run_op(8'h20, 4'h3, q, r, z, lat);
        chk("post_reset_result", {q, r, z}, {8'h0A, 4'h2, 1'b0});

        for (int i = 0; i < 60; i++)
            run_model(8'($urandom_range(0, 255)),
                      $urandom_range(0, 7) == 0 ? 4'h0 : 4'($urandom_range(1, 15)));

        // reverse every non-trivial 4x4 product
        for (int a = 0; a < 16; a++)
            for (int b = 1; b < 16; b++) begin
                run_op(8'(a * b), 4'(b), q, r, z, lat);
                chk($sformatf("prod_%0dx%0d", a, b), {q, r, z}, {8'(a), 4'h0, 1'b0});
            end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
